// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the IF-stage interrupt sequencer.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [31:0] VEC_BASE_DEF   = 32'h20;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h8;

   // Source id width; a single source still needs one bit.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index of i_req wins.
module int_prio_enc
   import int_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 3
) (
   input  logic [N_SRC-1:0]        i_req,
   output logic                    o_valid,
   output logic [id_w(N_SRC)-1:0]  o_id
);

   localparam int unsigned ID_W = id_w(N_SRC);

   always_comb begin
      o_valid = 1'b0;
      o_id    = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (i_req[i] && !o_valid) begin
            o_valid = 1'b1;
            o_id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/int_controller.sv
// Interrupt sequencer for IF: edge-latched IRQs, mask, priority pick, safe-cycle vector take, ERET retire.
// Define INT_NEST_EN to enable preemption by higher-priority sources through an EPC/id stack.
module int_controller
   import int_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC      = 3,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
   parameter int unsigned NEST_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    CLR,
   input  logic [N_SRC-1:0]        irq_in,
   input  logic                    mask_we,
   input  logic [N_SRC-1:0]        mask_wdata,
   input  logic                    PC_EN,
   input  logic                    J,
   input  logic                    Branch,
   input  logic                    ERET,
   input  logic [31:0]             if_pc_next,
   output logic                    Int,
   output logic [31:0]             Iaddr,
   output logic [31:0]             EPC,
   output logic                    int_active,
   output logic [id_w(N_SRC)-1:0]  int_id,
   output logic [15:0]             int_count
);

   localparam int unsigned ID_W = id_w(N_SRC);

   if (NEST_DEPTH == 0) begin : g_bad_depth
      $error("NEST_DEPTH must be at least 1");
   end

   state_t           r_state, w_state_nxt;
   logic [N_SRC-1:0] r_irq_prev, r_pending, r_mask;
   logic [N_SRC-1:0] w_edge, w_clr;
   logic [ID_W-1:0]  r_sel_id, r_int_id, w_sel_id;
   logic [31:0]      r_iaddr, r_epc, w_vec;
   logic [15:0]      r_count;
   logic             w_sel_valid, w_take, w_load_vec, w_accept;

`ifdef INT_NEST_EN
   localparam int unsigned SP_W  = $clog2(NEST_DEPTH + 1);
   localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
   logic [SP_W-1:0]  r_sp;
   logic             r_preempt, w_pop, w_stack_full, w_stack_empty;
   logic [31:0]      r_stk_epc [NEST_DEPTH];
   logic [ID_W-1:0]  r_stk_id  [NEST_DEPTH];
   assign w_stack_full  = (r_sp == SP_W'(NEST_DEPTH));
   assign w_stack_empty = (r_sp == '0);
`endif

   int_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
      .i_req   (r_pending & r_mask),
      .o_valid (w_sel_valid),
      .o_id    (w_sel_id)
   );

   assign w_edge = irq_in & ~r_irq_prev;
   assign w_clr  = w_accept ? (N_SRC'(1) << r_sel_id) : '0;
   assign w_vec  = VEC_BASE + (32'(w_sel_id) * VEC_STRIDE);
   assign w_take = PC_EN & ~J & ~Branch & ~ERET;

   assign Iaddr     = r_iaddr;
   assign EPC       = r_epc;
   assign int_id    = r_int_id;
   assign int_count = r_count;

   always_ff @(posedge clk) begin
      if (CLR) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      Int         = 1'b0;
      int_active  = 1'b0;
      w_load_vec  = 1'b0;
      w_accept    = 1'b0;
`ifdef INT_NEST_EN
      w_pop       = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_load_vec  = 1'b1;
               w_state_nxt = REQ;
            end
         end
         // Vector is held until a fetch cycle with no competing redirect.
         REQ: begin
            Int = w_take;
            if (w_take) begin
               w_accept    = 1'b1;
               w_state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            int_active = 1'b1;
            if (ERET && PC_EN) begin
`ifdef INT_NEST_EN
               if (!w_stack_empty) w_pop = 1'b1;
               else                w_state_nxt = IDLE;
`else
               w_state_nxt = IDLE;
`endif
            end
`ifdef INT_NEST_EN
            else if (w_sel_valid && (w_sel_id < r_int_id) && !w_stack_full) begin
               w_load_vec  = 1'b1;
               w_state_nxt = REQ;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (CLR) begin
         r_irq_prev <= '0;
         r_pending  <= '0;
         r_mask     <= '1;
         r_sel_id   <= '0;
         r_iaddr    <= '0;
         r_epc      <= '0;
         r_int_id   <= '0;
         r_count    <= '0;
`ifdef INT_NEST_EN
         r_sp       <= '0;
         r_preempt  <= 1'b0;
`endif
      end else begin
         r_irq_prev <= irq_in;
         r_pending  <= (r_pending & ~w_clr) | w_edge;
         if (mask_we) r_mask <= mask_wdata;
         if (w_load_vec) begin
            r_iaddr  <= w_vec;
            r_sel_id <= w_sel_id;
         end
         if (w_accept) begin
            r_epc    <= if_pc_next;
            r_int_id <= r_sel_id;
            if (r_count != '1) r_count <= r_count + 16'd1;
         end
`ifdef INT_NEST_EN
         if (w_load_vec) r_preempt <= (r_state == SERVICE);
         if (w_accept && r_preempt) r_sp <= r_sp + SP_W'(1);
         if (w_pop) begin
            r_epc    <= r_stk_epc[IDX_W'(r_sp - SP_W'(1))];
            r_int_id <= r_stk_id[IDX_W'(r_sp - SP_W'(1))];
            r_sp     <= r_sp - SP_W'(1);
         end
`endif
      end
   end

`ifdef INT_NEST_EN
   // Interrupted context saved when a preempting vector is taken.
   always_ff @(posedge clk) begin
      if (w_accept && r_preempt) begin
         r_stk_epc[IDX_W'(r_sp)] <= r_epc;
         r_stk_id[IDX_W'(r_sp)]  <= r_int_id;
      end
   end
`endif

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus a randomized run against a behavioural model.
module tb_int_controller;

   logic        clk = 1'b0;
   logic        CLR, mask_we, PC_EN, J, Branch, ERET;
   logic [2:0]  irq_in, mask_wdata;
   logic [31:0] if_pc_next;
   logic        Int, int_active;
   logic [31:0] Iaddr, EPC;
   logic [1:0]  int_id;
   logic [15:0] int_count;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef INT_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   int_controller dut (
      .clk(clk), .CLR(CLR), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .PC_EN(PC_EN), .J(J), .Branch(Branch), .ERET(ERET), .if_pc_next(if_pc_next),
      .Int(Int), .Iaddr(Iaddr), .EPC(EPC), .int_active(int_active), .int_id(int_id),
      .int_count(int_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model state: plain bits, an int mode and queues for the nesting stack.
   logic [2:0]  m_pend, m_prev, m_mask;
   int          m_mode;     // 0 nothing, 1 vector offered, 2 in service
   int          m_sel, m_id, m_count;
   bit          m_from_srv;
   logic [31:0] m_iaddr, m_epc;
   logic [31:0] stk_epc[$];
   int          stk_id[$];

   task automatic model_reset;
      m_pend = '0; m_prev = '0; m_mask = 3'b111; m_mode = 0; m_sel = 0; m_id = 0;
      m_count = 0; m_from_srv = 1'b0; m_iaddr = '0; m_epc = '0;
      stk_epc.delete(); stk_id.delete();
   endtask

   task automatic model_step;
      int pick;
      logic [2:0] edges, clr;
      bit take;
      if (CLR) begin
         model_reset();
         return;
      end
      edges = irq_in & ~m_prev;
      pick  = -1;
      for (int i = 2; i >= 0; i--) if (m_pend[i] && m_mask[i]) pick = i;
      clr  = '0;
      take = (m_mode == 1) && PC_EN && !J && !Branch && !ERET;
      case (m_mode)
         0: if (pick >= 0) begin
               m_mode = 1; m_sel = pick; m_from_srv = 1'b0;
               m_iaddr = 32'h20 + 32'(pick) * 32'h8;
            end
         1: if (take) begin
               if (m_from_srv) begin
                  stk_epc.push_back(m_epc);
                  stk_id.push_back(m_id);
               end
               m_epc = if_pc_next; clr[m_sel] = 1'b1; m_id = m_sel; m_mode = 2;
               if (m_count < 65535) m_count++;
            end
         default: begin
            if (ERET && PC_EN) begin
               if (stk_epc.size() > 0) begin
                  m_epc = stk_epc.pop_back();
                  m_id  = stk_id.pop_back();
               end else m_mode = 0;
            end else if (NEST && pick >= 0 && pick < m_id && stk_epc.size() < 4) begin
               m_mode = 1; m_sel = pick; m_from_srv = 1'b1;
               m_iaddr = 32'h20 + 32'(pick) * 32'h8;
            end
         end
      endcase
      m_pend = (m_pend & ~clr) | edges;
      m_prev = irq_in;
      if (mask_we) m_mask = mask_wdata;
   endtask

   // Waits (bounded) for the Int strobe; returns at #1 inside the strobe cycle when found.
   task automatic wait_int(output bit ok);
      int k;
      ok = 1'b0; k = 0;
      while (!ok && k < 10) begin
         #1;
         if (Int === 1'b1) ok = 1'b1;
         else begin
            k++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      CLR = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; PC_EN = 1'b0;
      J = 1'b0; Branch = 1'b0; ERET = 1'b0; if_pc_next = '0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", Int); end
      n_cmp++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", int_active); end
      n_cmp++; if (Iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", Iaddr); end
      n_cmp++; if (EPC !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", EPC); end
      n_cmp++; if (int_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", int_id); end
      n_cmp++; if (int_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", int_count); end
      @(negedge clk);
      CLR = 1'b0;
   endtask

   task automatic test_idle_take;
      PC_EN = 1'b1; if_pc_next = 32'h40; irq_in = 3'b010;
      #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL take_int_n: got %b want 0", Int); end
      @(negedge clk); #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL take_int_n1: got %b want 0", Int); end
      @(negedge clk); #1;
      n_cmp++; if (Int !== 1'b1) begin n_fail++; $display("FAIL take_int_n2: got %b want 1", Int); end
      n_cmp++; if (Iaddr !== 32'h28) begin n_fail++; $display("FAIL take_iaddr: got %h want 28", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL take_int_after: got %b want 0", Int); end
      n_cmp++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL take_active: got %b want 1", int_active); end
      n_cmp++; if (EPC !== 32'h40) begin n_fail++; $display("FAIL take_epc: got %h want 40", EPC); end
      n_cmp++; if (int_id !== 2'd1) begin n_fail++; $display("FAIL take_id: got %0d want 1", int_id); end
      n_cmp++; if (int_count !== 16'd1) begin n_fail++; $display("FAIL take_count: got %0d want 1", int_count); end
      @(negedge clk); ERET = 1'b0; irq_in = '0; #1;
      n_cmp++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL take_eret_idle: got %b want 0", int_active); end
      @(negedge clk);
   endtask

   task automatic test_branch_collision;
      irq_in = 3'b100; if_pc_next = 32'h0;
      @(negedge clk);
      @(negedge clk); Branch = 1'b1; #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL br_int_c0: got %b want 0", Int); end
      n_cmp++; if (Iaddr !== 32'h30) begin n_fail++; $display("FAIL br_iaddr: got %h want 30", Iaddr); end
      @(negedge clk); if_pc_next = 32'h80; #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL br_int_c1: got %b want 0", Int); end
      @(negedge clk); Branch = 1'b0; if_pc_next = 32'h100; #1;
      n_cmp++; if (Int !== 1'b1) begin n_fail++; $display("FAIL br_int_free: got %b want 1", Int); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (EPC !== 32'h100) begin n_fail++; $display("FAIL br_epc: got %h want 100", EPC); end
      n_cmp++; if (int_id !== 2'd2) begin n_fail++; $display("FAIL br_id: got %0d want 2", int_id); end
      n_cmp++; if (int_count !== 16'd2) begin n_fail++; $display("FAIL br_count: got %0d want 2", int_count); end
      @(negedge clk); ERET = 1'b0; irq_in = '0;
      @(negedge clk);
   endtask

   task automatic test_prio_mask;
      bit ok;
      mask_we = 1'b1; mask_wdata = 3'b110;
      @(negedge clk); mask_we = 1'b0; irq_in = 3'b101;
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL pm_first_take: got no Int want Int within 10 cycles"); end
      n_cmp++; if (Iaddr !== 32'h30) begin n_fail++; $display("FAIL pm_iaddr_src2: got %h want 30", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (int_id !== 2'd2) begin n_fail++; $display("FAIL pm_id_src2: got %0d want 2", int_id); end
      @(negedge clk); ERET = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL pm_masked_hold%0d: got %b want 0", c, Int); end
         @(negedge clk);
      end
      mask_we = 1'b1; mask_wdata = 3'b111;
      @(negedge clk); mask_we = 1'b0;
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL pm_second_take: got no Int want Int within 10 cycles"); end
      n_cmp++; if (Iaddr !== 32'h20) begin n_fail++; $display("FAIL pm_iaddr_src0: got %h want 20", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (int_id !== 2'd0) begin n_fail++; $display("FAIL pm_id_src0: got %0d want 0", int_id); end
      n_cmp++; if (int_count !== 16'd4) begin n_fail++; $display("FAIL pm_count: got %0d want 4", int_count); end
      @(negedge clk); ERET = 1'b0; irq_in = '0;
      @(negedge clk);
   endtask

   task automatic test_eret;
      bit ok;
      irq_in = 3'b010; if_pc_next = 32'h500;
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL eret_take: got no Int want Int within 10 cycles"); end
      @(negedge clk); ERET = 1'b1; PC_EN = 1'b0; #1;
      n_cmp++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL eret_svc: got %b want 1", int_active); end
      @(negedge clk); PC_EN = 1'b1; #1;
      n_cmp++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL eret_stall_ignored: got %b want 1", int_active); end
      @(negedge clk); if_pc_next = 32'h600; #1;
      n_cmp++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL eret_to_idle: got %b want 0", int_active); end
      @(negedge clk); ERET = 1'b0; #1;
      n_cmp++; if (EPC !== 32'h500) begin n_fail++; $display("FAIL eret_idle_epc: got %h want 500", EPC); end
      n_cmp++; if (int_count !== 16'd5) begin n_fail++; $display("FAIL eret_count: got %0d want 5", int_count); end
      irq_in = '0;
      @(negedge clk);
   endtask

   task automatic test_nesting;
      bit ok;
      irq_in = 3'b100; if_pc_next = 32'h200;
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL nest_take2: got no Int want Int within 10 cycles"); end
      @(negedge clk); irq_in = 3'b101; if_pc_next = 32'h300; #1;
      n_cmp++; if (int_id !== 2'd2) begin n_fail++; $display("FAIL nest_id2: got %0d want 2", int_id); end
`ifdef INT_NEST_EN
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL nest_preempt: got no Int want Int within 10 cycles"); end
      n_cmp++; if (Iaddr !== 32'h20) begin n_fail++; $display("FAIL nest_iaddr: got %h want 20", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (EPC !== 32'h300) begin n_fail++; $display("FAIL nest_epc_new: got %h want 300", EPC); end
      n_cmp++; if (int_id !== 2'd0) begin n_fail++; $display("FAIL nest_id0: got %0d want 0", int_id); end
      @(negedge clk); #1;
      n_cmp++; if (EPC !== 32'h200) begin n_fail++; $display("FAIL nest_epc_pop: got %h want 200", EPC); end
      n_cmp++; if (int_id !== 2'd2) begin n_fail++; $display("FAIL nest_id_pop: got %0d want 2", int_id); end
      n_cmp++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL nest_active_pop: got %b want 1", int_active); end
      @(negedge clk); ERET = 1'b0; #1;
      n_cmp++; if (int_active !== 1'b0) begin n_fail++; $display("FAIL nest_idle: got %b want 0", int_active); end
`else
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL nonest_wait%0d: got %b want 0", c, Int); end
      end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (int_active !== 1'b1) begin n_fail++; $display("FAIL nonest_active: got %b want 1", int_active); end
      @(negedge clk); ERET = 1'b0;
      wait_int(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL nonest_take0: got no Int want Int within 10 cycles"); end
      n_cmp++; if (Iaddr !== 32'h20) begin n_fail++; $display("FAIL nonest_iaddr: got %h want 20", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (int_id !== 2'd0) begin n_fail++; $display("FAIL nonest_id0: got %0d want 0", int_id); end
      n_cmp++; if (EPC !== 32'h300) begin n_fail++; $display("FAIL nonest_epc: got %h want 300", EPC); end
      @(negedge clk); ERET = 1'b0;
`endif
      irq_in = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_req;
      PC_EN = 1'b0; irq_in = 3'b010;
      @(negedge clk);
      @(negedge clk); CLR = 1'b1; #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL rst_req_int: got %b want 0", Int); end
      @(negedge clk); CLR = 1'b0; PC_EN = 1'b1; #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL rst_after_int: got %b want 0", Int); end
      n_cmp++; if (int_count !== 16'd0) begin n_fail++; $display("FAIL rst_after_count: got %0d want 0", int_count); end
      n_cmp++; if (Iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_after_iaddr: got %h want 0", Iaddr); end
      n_cmp++; if (EPC !== 32'h0) begin n_fail++; $display("FAIL rst_after_epc: got %h want 0", EPC); end
      @(negedge clk); #1;
      n_cmp++; if (Int !== 1'b0) begin n_fail++; $display("FAIL rst_pend_int: got %b want 0", Int); end
      @(negedge clk); #1;
      n_cmp++; if (Int !== 1'b1) begin n_fail++; $display("FAIL rst_retake_int: got %b want 1", Int); end
      n_cmp++; if (Iaddr !== 32'h28) begin n_fail++; $display("FAIL rst_retake_iaddr: got %h want 28", Iaddr); end
      @(negedge clk); ERET = 1'b1; #1;
      n_cmp++; if (int_count !== 16'd1) begin n_fail++; $display("FAIL rst_retake_count: got %0d want 1", int_count); end
      n_cmp++; if (int_id !== 2'd1) begin n_fail++; $display("FAIL rst_retake_id: got %0d want 1", int_id); end
      @(negedge clk); ERET = 1'b0; irq_in = '0;
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [2:0] flip;
      bit         e_int, e_act;
      CLR = 1'b1; irq_in = '0; mask_we = 1'b0; PC_EN = 1'b0; J = 1'b0; Branch = 1'b0; ERET = 1'b0;
      @(negedge clk);
      model_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         CLR = ($urandom_range(0, 199) == 0);
         for (int b = 0; b < 3; b++) flip[b] = ($urandom_range(0, 5) == 0);
         irq_in     = irq_in ^ flip;
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = 3'($urandom);
         PC_EN      = ($urandom_range(0, 3) != 0);
         J          = ($urandom_range(0, 7) == 0);
         Branch     = ($urandom_range(0, 7) == 0);
         ERET       = ($urandom_range(0, 5) == 0);
         if_pc_next = $urandom;
         #1;
         e_int = (m_mode == 1) && PC_EN && !J && !Branch && !ERET;
         e_act = (m_mode == 2);
         n_cmp++; if (Int !== e_int) begin n_fail++; $display("FAIL rnd_int c%0d: got %b want %b", cyc, Int, e_int); end
         n_cmp++; if (int_active !== e_act) begin n_fail++; $display("FAIL rnd_active c%0d: got %b want %b", cyc, int_active, e_act); end
         n_cmp++; if (Iaddr !== m_iaddr) begin n_fail++; $display("FAIL rnd_iaddr c%0d: got %h want %h", cyc, Iaddr, m_iaddr); end
         n_cmp++; if (EPC !== m_epc) begin n_fail++; $display("FAIL rnd_epc c%0d: got %h want %h", cyc, EPC, m_epc); end
         n_cmp++; if (int_id !== 2'(m_id)) begin n_fail++; $display("FAIL rnd_id c%0d: got %0d want %0d", cyc, int_id, m_id); end
         n_cmp++; if (int_count !== 16'(m_count)) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, int_count, m_count); end
         model_step();
         @(negedge clk);
      end
      CLR = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle_take();
      test_branch_collision();
      test_prio_mask();
      test_eret();
      test_nesting();
      test_reset_mid_req();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
